// File: rtl/wb_stage.sv
// Write-back stage: holds one instruction from MEM, formats load data on capture,
// drives the register-file write port and counts retired instructions.
module wb_stage #(
   parameter int XLEN  = 32,
   parameter int RA_W  = 5,
   parameter int CNT_W = 64
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             mem_valid,
   output logic             mem_ready,
   input  logic [XLEN-1:0]  mem_alu_result,
   input  logic [XLEN-1:0]  mem_load_data,
   input  logic [XLEN-1:0]  mem_pc_plus4,
   input  logic [RA_W-1:0]  mem_rd,
   input  logic             mem_reg_write,
   input  logic [1:0]       mem_wb_sel,
   input  logic [2:0]       mem_funct3,
   input  logic [1:0]       mem_addr_lo,
   input  logic             wb_stall,
   input  logic             wb_flush,
   output logic             wb_we,
   output logic [RA_W-1:0]  wb_rd,
   output logic [XLEN-1:0]  wb_data,
   output logic             wb_misalign,
   output logic [CNT_W-1:0] retire_count
);

   logic             valid_q, valid_d;
   logic             we_q, we_d;
   logic             misalign_q, misalign_d;
   logic [RA_W-1:0]  rd_q, rd_d;
   logic [XLEN-1:0]  data_q, data_d;
   logic [CNT_W-1:0] count_q, count_d;

   logic             capture;
   logic             retire;
   logic [7:0]       loadByte;
   logic [15:0]      loadHalf;
   logic [XLEN-1:0]  loadFmt;
   logic [XLEN-1:0]  selData;
   logic             loadMisalign;

   assign mem_ready = !valid_q || !wb_stall;
   // Flush kills both the held entry and any capture attempted in the same cycle.
   assign capture   = mem_valid && mem_ready && !wb_flush;
   assign retire    = valid_q && !wb_stall && !wb_flush;

   always_comb begin
      loadByte = mem_load_data[7:0];
      case (mem_addr_lo)
         2'd1:    loadByte = mem_load_data[15:8];
         2'd2:    loadByte = mem_load_data[23:16];
         2'd3:    loadByte = mem_load_data[31:24];
         default: loadByte = mem_load_data[7:0];
      endcase
      loadHalf = mem_addr_lo[1] ? mem_load_data[31:16] : mem_load_data[15:0];

      case (mem_funct3)
         3'b000:  loadFmt = XLEN'($signed(loadByte));
         3'b001:  loadFmt = XLEN'($signed(loadHalf));
         3'b010:  loadFmt = XLEN'($signed(mem_load_data[31:0]));
         3'b100:  loadFmt = XLEN'(loadByte);
         3'b101:  loadFmt = XLEN'(loadHalf);
         default: loadFmt = mem_load_data;
      endcase

      loadMisalign = 1'b0;
      if (mem_wb_sel == 2'b01) begin
         case (mem_funct3)
            3'b001, 3'b101: loadMisalign = mem_addr_lo[0];
            3'b010:         loadMisalign = (mem_addr_lo != 2'b00);
            default:        loadMisalign = 1'b0;
         endcase
      end

      case (mem_wb_sel)
         2'b01:   selData = loadFmt;
         2'b10:   selData = mem_pc_plus4;
         default: selData = mem_alu_result;
      endcase
   end

   // Flush wins over capture; a retire with no replacement empties the slot.
   always_comb begin
      valid_d    = valid_q;
      we_d       = we_q;
      rd_d       = rd_q;
      data_d     = data_q;
      misalign_d = misalign_q;
      count_d    = count_q;

      if (retire) count_d = count_q + CNT_W'(1);

      if (wb_flush) begin
         valid_d = 1'b0;
      end else if (capture) begin
         valid_d    = 1'b1;
         we_d       = mem_reg_write;
         rd_d       = mem_rd;
         data_d     = selData;
         misalign_d = loadMisalign;
      end else if (retire) begin
         valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         valid_q    <= 1'b0;
         we_q       <= 1'b0;
         rd_q       <= '0;
         data_q     <= '0;
         misalign_q <= 1'b0;
         count_q    <= '0;
      end else begin
         valid_q    <= valid_d;
         we_q       <= we_d;
         rd_q       <= rd_d;
         data_q     <= data_d;
         misalign_q <= misalign_d;
         count_q    <= count_d;
      end
   end

   assign wb_we        = valid_q && we_q && (rd_q != '0) && !misalign_q && !wb_stall;
   assign wb_rd        = rd_q;
   assign wb_data      = data_q;
   assign wb_misalign  = misalign_q;
   assign retire_count = count_q;

endmodule

// File: tb/tb_wb_stage.sv
// Scoreboard bench for wb_stage: expected write-backs are queued as stimulus is
// driven and popped when the stage presents them; retire count tracked separately.
module tb_wb_stage;

   logic        clk = 1'b0;
   logic        rst;
   logic        mem_valid;
   logic        mem_ready;
   logic [31:0] mem_alu_result;
   logic [31:0] mem_load_data;
   logic [31:0] mem_pc_plus4;
   logic [4:0]  mem_rd;
   logic        mem_reg_write;
   logic [1:0]  mem_wb_sel;
   logic [2:0]  mem_funct3;
   logic [1:0]  mem_addr_lo;
   logic        wb_stall;
   logic        wb_flush;
   logic        wb_we;
   logic [4:0]  wb_rd;
   logic [31:0] wb_data;
   logic        wb_misalign;
   logic [3:0]  retire_count;

   typedef struct packed {
      logic [4:0]  rd;
      logic [31:0] data;
      logic        mis;
      logic        we;
   } exp_t;

   exp_t sb[$];
   int   checks   = 0;
   int   errors   = 0;
   int   expCount = 0;

   wb_stage #(.XLEN(32), .RA_W(5), .CNT_W(4)) dut (
      .clk(clk), .rst(rst),
      .mem_valid(mem_valid), .mem_ready(mem_ready),
      .mem_alu_result(mem_alu_result), .mem_load_data(mem_load_data),
      .mem_pc_plus4(mem_pc_plus4), .mem_rd(mem_rd),
      .mem_reg_write(mem_reg_write), .mem_wb_sel(mem_wb_sel),
      .mem_funct3(mem_funct3), .mem_addr_lo(mem_addr_lo),
      .wb_stall(wb_stall), .wb_flush(wb_flush),
      .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
      .wb_misalign(wb_misalign), .retire_count(retire_count)
   );

   always #5 clk = ~clk;

   // Independent reference for load formatting: shift the word down, then extend.
   function automatic logic [31:0] expLoad(input logic [31:0] ld, input logic [2:0] f3,
                                           input logic [1:0] alo);
      logic [31:0] sh;
      logic [31:0] hs;
      sh = ld >> (8 * alo);
      hs = ld >> (16 * alo[1]);
      case (f3)
         3'b000:  return {{24{sh[7]}}, sh[7:0]};
         3'b001:  return {{16{hs[15]}}, hs[15:0]};
         3'b100:  return {24'h0, sh[7:0]};
         3'b101:  return {16'h0, hs[15:0]};
         default: return ld;
      endcase
   endfunction

   function automatic logic expMis(input logic [1:0] sel, input logic [2:0] f3,
                                   input logic [1:0] alo);
      if (sel != 2'b01) return 1'b0;
      if ((f3 == 3'b001 || f3 == 3'b101) && alo[0]) return 1'b1;
      if (f3 == 3'b010 && alo != 2'b00) return 1'b1;
      return 1'b0;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus(input logic [31:0] alu, input logic [31:0] ld,
                                input logic [31:0] pc4, input logic [4:0] rd,
                                input logic rw, input logic [1:0] sel,
                                input logic [2:0] f3, input logic [1:0] alo);
      mem_alu_result = alu;
      mem_load_data  = ld;
      mem_pc_plus4   = pc4;
      mem_rd         = rd;
      mem_reg_write  = rw;
      mem_wb_sel     = sel;
      mem_funct3     = f3;
      mem_addr_lo    = alo;
      mem_valid      = 1'b1;
   endtask

   task automatic pushExpected(input logic [31:0] alu, input logic [31:0] ld,
                               input logic [31:0] pc4, input logic [4:0] rd,
                               input logic rw, input logic [1:0] sel,
                               input logic [2:0] f3, input logic [1:0] alo);
      exp_t e;
      e.rd   = rd;
      e.mis  = expMis(sel, f3, alo);
      e.data = (sel == 2'b01) ? expLoad(ld, f3, alo) : (sel == 2'b10) ? pc4 : alu;
      e.we   = rw && (rd != 5'd0) && !e.mis;
      sb.push_back(e);
   endtask

   task automatic test_reset();
      rst = 1'b1; mem_valid = 1'b0; wb_stall = 1'b0; wb_flush = 1'b0;
      applyStimulus(32'h0, 32'h0, 32'h0, 5'd0, 1'b0, 2'b00, 3'b000, 2'b00);
      mem_valid = 1'b0;
      tick(); tick();
      rst = 1'b0;
      #1;
      checks++; if (wb_we !== 1'b0) begin errors++; $display("[TB] FAIL reset_we got %b want 0", wb_we); end
      checks++; if (mem_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_ready got %b want 1", mem_ready); end
      checks++; if (wb_rd !== 5'd0 || wb_data !== 32'h0 || wb_misalign !== 1'b0) begin
         errors++; $display("[TB] FAIL reset_regs got rd=%0d data=%h mis=%b want 0", wb_rd, wb_data, wb_misalign); end
      checks++; if (retire_count !== 4'd0) begin errors++; $display("[TB] FAIL reset_count got %0d want 0", retire_count); end
      expCount = 0;
   endtask

   task automatic test_alu();
      exp_t e;
      applyStimulus(32'h1234_5678, 32'h0, 32'h0, 5'd5, 1'b1, 2'b00, 3'b000, 2'b00);
      pushExpected(32'h1234_5678, 32'h0, 32'h0, 5'd5, 1'b1, 2'b00, 3'b000, 2'b00);
      tick();
      mem_valid = 1'b0;
      #1;
      e = sb.pop_front();
      checks++; if (wb_we !== 1'b1) begin errors++; $display("[TB] FAIL alu_we got %b want 1", wb_we); end
      checks++; if (wb_rd !== e.rd) begin errors++; $display("[TB] FAIL alu_rd got %0d want %0d", wb_rd, e.rd); end
      checks++; if (wb_data !== e.data) begin errors++; $display("[TB] FAIL alu_data got %h want %h", wb_data, e.data); end
      expCount++;
      tick();
      checks++; if (retire_count !== 4'(expCount)) begin errors++; $display("[TB] FAIL alu_count got %0d want %0d", retire_count, expCount); end
      checks++; if (wb_we !== 1'b0) begin errors++; $display("[TB] FAIL alu_we_after got %b want 0", wb_we); end
   endtask

   // Loads and sources issued back to back, one per cycle.
   task automatic test_back_to_back();
      logic [2:0]  f3s [9] = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b010, 3'b001, 3'b011, 3'b000, 3'b000};
      logic [1:0]  alos[9] = '{2'd3, 2'd2, 2'd2, 2'd0, 2'd0, 2'd1, 2'd0, 2'd0, 2'd0};
      logic [1:0]  sels[9] = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b01, 2'b01, 2'b01, 2'b10, 2'b11};
      logic [31:0] word;
      exp_t e;
      word = 32'h80FF_7F01;
      for (int i = 0; i < 9; i++) begin
         applyStimulus(32'hA5A5_0000 + 32'(i), word, 32'h0000_0104, 5'(i + 1), 1'b1, sels[i], f3s[i], alos[i]);
         pushExpected(32'hA5A5_0000 + 32'(i), word, 32'h0000_0104, 5'(i + 1), 1'b1, sels[i], f3s[i], alos[i]);
         tick();
         e = sb.pop_front();
         checks++; if (wb_data !== e.data) begin errors++; $display("[TB] FAIL b2b_data[%0d] got %h want %h", i, wb_data, e.data); end
         checks++; if (wb_misalign !== e.mis || wb_we !== e.we) begin
            errors++; $display("[TB] FAIL b2b_ctl[%0d] got mis=%b we=%b want mis=%b we=%b", i, wb_misalign, wb_we, e.mis, e.we); end
         checks++; if (retire_count !== 4'(expCount)) begin errors++; $display("[TB] FAIL b2b_count[%0d] got %0d want %0d", i, retire_count, expCount); end
         expCount++;
      end
      mem_valid = 1'b0;
      tick();
      checks++; if (retire_count !== 4'(expCount)) begin errors++; $display("[TB] FAIL b2b_count_end got %0d want %0d", retire_count, expCount); end
   endtask

   task automatic test_misalign();
      exp_t e;
      applyStimulus(32'h0, 32'hCAFE_BABE, 32'h0, 5'd7, 1'b1, 2'b01, 3'b010, 2'd2);
      pushExpected(32'h0, 32'hCAFE_BABE, 32'h0, 5'd7, 1'b1, 2'b01, 3'b010, 2'd2);
      tick();
      mem_valid = 1'b0;
      #1;
      e = sb.pop_front();
      checks++; if (wb_misalign !== 1'b1) begin errors++; $display("[TB] FAIL lw_mis got %b want 1", wb_misalign); end
      checks++; if (wb_we !== e.we) begin errors++; $display("[TB] FAIL lw_mis_we got %b want %b", wb_we, e.we); end
      expCount++;
      tick();
      checks++; if (retire_count !== 4'(expCount)) begin errors++; $display("[TB] FAIL lw_mis_count got %0d want %0d", retire_count, expCount); end
   endtask

   task automatic test_stall();
      exp_t a;
      exp_t b;
      applyStimulus(32'h0BAD_F00D, 32'h0, 32'h0, 5'd3, 1'b1, 2'b00, 3'b000, 2'd0);
      pushExpected(32'h0BAD_F00D, 32'h0, 32'h0, 5'd3, 1'b1, 2'b00, 3'b000, 2'd0);
      tick();
      a = sb.pop_front();
      applyStimulus(32'h1111_2222, 32'h0, 32'h0, 5'd4, 1'b1, 2'b00, 3'b000, 2'd0);
      wb_stall = 1'b1;
      #1;
      for (int k = 0; k < 3; k++) begin
         checks++; if (mem_ready !== 1'b0 || wb_we !== 1'b0) begin
            errors++; $display("[TB] FAIL stall_ctl[%0d] got ready=%b we=%b want 0 0", k, mem_ready, wb_we); end
         checks++; if (wb_data !== a.data || wb_rd !== a.rd || wb_misalign !== a.mis) begin
            errors++; $display("[TB] FAIL stall_hold[%0d] got rd=%0d data=%h want rd=%0d data=%h", k, wb_rd, wb_data, a.rd, a.data); end
         checks++; if (retire_count !== 4'(expCount)) begin errors++; $display("[TB] FAIL stall_count[%0d] got %0d want %0d", k, retire_count, expCount); end
         if (k < 2) tick();
      end
      wb_stall = 1'b0;
      pushExpected(32'h1111_2222, 32'h0, 32'h0, 5'd4, 1'b1, 2'b00, 3'b000, 2'd0);
      #1;
      checks++; if (wb_we !== 1'b1 || mem_ready !== 1'b1) begin
         errors++; $display("[TB] FAIL stall_release got we=%b ready=%b want 1 1", wb_we, mem_ready); end
      expCount++;
      tick();
      mem_valid = 1'b0;
      #1;
      b = sb.pop_front();
      checks++; if (wb_rd !== b.rd || wb_data !== b.data) begin
         errors++; $display("[TB] FAIL stall_next got rd=%0d data=%h want rd=%0d data=%h", wb_rd, wb_data, b.rd, b.data); end
      checks++; if (retire_count !== 4'(expCount)) begin errors++; $display("[TB] FAIL stall_next_count got %0d want %0d", retire_count, expCount); end
      expCount++;
      tick();
      checks++; if (retire_count !== 4'(expCount) || wb_we !== 1'b0) begin
         errors++; $display("[TB] FAIL stall_drain got count=%0d we=%b want %0d 0", retire_count, wb_we, expCount); end
   endtask

   task automatic test_flush();
      exp_t e;
      applyStimulus(32'h5555_AAAA, 32'h0, 32'h0, 5'd9, 1'b1, 2'b00, 3'b000, 2'd0);
      pushExpected(32'h5555_AAAA, 32'h0, 32'h0, 5'd9, 1'b1, 2'b00, 3'b000, 2'd0);
      tick();
      e = sb.pop_front();
      checks++; if (wb_rd !== e.rd || wb_data !== e.data) begin
         errors++; $display("[TB] FAIL flush_held got rd=%0d data=%h want rd=%0d data=%h", wb_rd, wb_data, e.rd, e.data); end
      applyStimulus(32'h6666_0000, 32'h0, 32'h0, 5'd10, 1'b1, 2'b00, 3'b000, 2'd0);
      wb_stall = 1'b1;
      wb_flush = 1'b1;
      #1;
      checks++; if (wb_we !== 1'b0) begin errors++; $display("[TB] FAIL flush_we got %b want 0", wb_we); end
      tick();
      wb_flush = 1'b0;
      mem_valid = 1'b0;
      #1;
      checks++; if (mem_ready !== 1'b1 || wb_we !== 1'b0) begin
         errors++; $display("[TB] FAIL flush_empty got ready=%b we=%b want 1 0", mem_ready, wb_we); end
      checks++; if (retire_count !== 4'(expCount)) begin errors++; $display("[TB] FAIL flush_count got %0d want %0d", retire_count, expCount); end
      wb_stall = 1'b0;
      tick();
      checks++; if (retire_count !== 4'(expCount)) begin errors++; $display("[TB] FAIL flush_count2 got %0d want %0d", retire_count, expCount); end

      applyStimulus(32'h0000_0077, 32'h0, 32'h0, 5'd0, 1'b1, 2'b00, 3'b000, 2'd0);
      pushExpected(32'h0000_0077, 32'h0, 32'h0, 5'd0, 1'b1, 2'b00, 3'b000, 2'd0);
      tick();
      mem_valid = 1'b0;
      #1;
      e = sb.pop_front();
      checks++; if (wb_we !== e.we || wb_data !== e.data) begin
         errors++; $display("[TB] FAIL rd0 got we=%b data=%h want we=%b data=%h", wb_we, wb_data, e.we, e.data); end
      expCount++;
      tick();
      checks++; if (retire_count !== 4'(expCount)) begin errors++; $display("[TB] FAIL rd0_count got %0d want %0d", retire_count, expCount); end
   endtask

   task automatic test_idle();
      mem_valid = 1'b0;
      for (int k = 0; k < 4; k++) begin
         tick();
         checks++; if (wb_we !== 1'b0 || retire_count !== 4'(expCount)) begin
            errors++; $display("[TB] FAIL idle[%0d] got we=%b count=%0d want 0 %0d", k, wb_we, retire_count, expCount); end
      end
   endtask

   // Sixteen consecutive retirements sweep every counter value, crossing 15 -> 0.
   task automatic test_wrap();
      exp_t e;
      for (int i = 0; i < 16; i++) begin
         applyStimulus(32'h0100_0000 + 32'(i), 32'h0, 32'h0, 5'((i % 31) + 1), 1'b1, 2'b00, 3'b000, 2'd0);
         pushExpected(32'h0100_0000 + 32'(i), 32'h0, 32'h0, 5'((i % 31) + 1), 1'b1, 2'b00, 3'b000, 2'd0);
         tick();
         e = sb.pop_front();
         checks++; if (wb_data !== e.data || retire_count !== 4'(expCount)) begin
            errors++; $display("[TB] FAIL wrap[%0d] got data=%h count=%0d want %h %0d", i, wb_data, retire_count, e.data, 4'(expCount)); end
         expCount++;
      end
      mem_valid = 1'b0;
      tick();
      checks++; if (retire_count !== 4'(expCount)) begin errors++; $display("[TB] FAIL wrap_end got %0d want %0d", retire_count, 4'(expCount)); end
   endtask

   task automatic test_reset_stall();
      applyStimulus(32'hFEED_0006, 32'h0, 32'h0, 5'd6, 1'b1, 2'b00, 3'b000, 2'd0);
      pushExpected(32'hFEED_0006, 32'h0, 32'h0, 5'd6, 1'b1, 2'b00, 3'b000, 2'd0);
      tick();
      void'(sb.pop_front());
      applyStimulus(32'hFEED_0008, 32'h0, 32'h0, 5'd8, 1'b1, 2'b00, 3'b000, 2'd0);
      wb_stall = 1'b1;
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      mem_valid = 1'b0;
      #1;
      checks++; if (mem_ready !== 1'b1 || wb_we !== 1'b0) begin
         errors++; $display("[TB] FAIL rst_stall_ctl got ready=%b we=%b want 1 0", mem_ready, wb_we); end
      checks++; if (wb_rd !== 5'd0 || wb_data !== 32'h0 || wb_misalign !== 1'b0 || retire_count !== 4'd0) begin
         errors++; $display("[TB] FAIL rst_stall_regs got rd=%0d data=%h mis=%b count=%0d want 0", wb_rd, wb_data, wb_misalign, retire_count); end
      wb_stall = 1'b0;
      expCount = 0;
      sb.delete();
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog expired");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      test_reset();
      test_alu();
      test_back_to_back();
      test_misalign();
      test_stall();
      test_flush();
      test_idle();
      test_wrap();
      test_reset_stall();
      checks++; if (sb.size() != 0) begin errors++; $display("[TB] FAIL scoreboard_left got %0d want 0", sb.size()); end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
